// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state and port-select encodings for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic SEL_P = 1'b0;
  localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/dmem_arb_select.sv
// rtl/dmem_arb_select.sv - pipeline-priority winner selection with a debug-port starvation guard
module dmem_arb_select
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p_req,
  input  logic d_req,
  input  logic in_idle,
  output logic grant,
  output logic sel
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] starve_cnt;
  logic          forced_d;

  always_comb begin
    forced_d = (starve_cnt == WAIT_LIMIT);
    grant    = in_idle && (p_req || d_req);
    if (d_req && (!p_req || forced_d)) begin
      sel = SEL_D;
    end else begin
      sel = SEL_P;
    end
  end

  // d_req with a P win implies both were requesting: that is a lost round for D.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (in_idle && d_req) begin
      if (sel == SEL_D) begin
        starve_cnt <= '0;
      end else if (!forced_d) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter sequencing fixed-latency accesses to the single-port data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                  I_CLOCK,
  input  logic                  I_RESET_N,
  input  logic                  I_P_REQ,
  input  logic                  I_P_WE,
  input  logic [ADDR_WIDTH-1:0] I_P_ADDR,
  input  logic [DATA_WIDTH-1:0] I_P_WDATA,
  output logic                  O_P_GNT,
  output logic                  O_P_VALID,
  output logic [DATA_WIDTH-1:0] O_P_RDATA,
  output logic                  O_P_STALL,
  input  logic                  I_D_REQ,
  input  logic                  I_D_WE,
  input  logic [ADDR_WIDTH-1:0] I_D_ADDR,
  input  logic [DATA_WIDTH-1:0] I_D_WDATA,
  output logic                  O_D_GNT,
  output logic                  O_D_VALID,
  output logic [DATA_WIDTH-1:0] O_D_RDATA,
  output logic                  O_M_EN,
  output logic                  O_M_WE,
  output logic [ADDR_WIDTH-1:0] O_M_ADDR,
  output logic [DATA_WIDTH-1:0] O_M_WDATA,
  input  logic [DATA_WIDTH-1:0] I_M_RDATA,
  output logic                  O_BUSY
);

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LATENCY - 1);

  state_t        state;
  state_t        next_state;
  logic [LW-1:0] lat_cnt;
  logic          serving;
  logic          grant;
  logic          win_sel;
  logic          start;
  logic          finish;

  dmem_arb_select #(
    .MAX_WAIT(MAX_WAIT)
  ) u_sel (
    .clk    (I_CLOCK),
    .rst_n  (I_RESET_N),
    .p_req  (I_P_REQ),
    .d_req  (I_D_REQ),
    .in_idle(state == IDLE),
    .grant  (grant),
    .sel    (win_sel)
  );

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = ACCESS;
      ACCESS:  if (lat_cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start  = (state == IDLE) && grant;
    finish = (state == ACCESS) && (lat_cnt == '0);
  end

  // GNT and VALID default low each edge so they only ever pulse for one cycle.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      lat_cnt   <= '0;
      serving   <= SEL_P;
      O_M_EN    <= 1'b0;
      O_M_WE    <= 1'b0;
      O_M_ADDR  <= '0;
      O_M_WDATA <= '0;
      O_P_GNT   <= 1'b0;
      O_D_GNT   <= 1'b0;
      O_P_VALID <= 1'b0;
      O_D_VALID <= 1'b0;
      O_P_RDATA <= '0;
      O_D_RDATA <= '0;
    end else begin
      O_P_GNT   <= 1'b0;
      O_D_GNT   <= 1'b0;
      O_P_VALID <= 1'b0;
      O_D_VALID <= 1'b0;
      if (start) begin
        serving   <= win_sel;
        O_M_EN    <= 1'b1;
        O_M_WE    <= (win_sel == SEL_D) ? I_D_WE    : I_P_WE;
        O_M_ADDR  <= (win_sel == SEL_D) ? I_D_ADDR  : I_P_ADDR;
        O_M_WDATA <= (win_sel == SEL_D) ? I_D_WDATA : I_P_WDATA;
        O_P_GNT   <= (win_sel == SEL_P);
        O_D_GNT   <= (win_sel == SEL_D);
        lat_cnt   <= LAT_LOAD;
      end else if (finish) begin
        O_M_EN <= 1'b0;
        O_M_WE <= 1'b0;
        if (serving == SEL_P) begin
          O_P_VALID <= 1'b1;
          if (!O_M_WE) O_P_RDATA <= I_M_RDATA;
        end else begin
          O_D_VALID <= 1'b1;
          if (!O_M_WE) O_D_RDATA <= I_M_RDATA;
        end
      end else if (state == ACCESS) begin
        lat_cnt <= lat_cnt - LW'(1);
      end
    end
  end

  assign O_P_STALL = I_P_REQ && !O_P_VALID;
  assign O_BUSY    = (state != IDLE);

endmodule
